// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-outstanding byte reads to instruction
// memory, buffers returned instructions in a small FIFO and presents the head
// to the decoder. A redirect flushes the FIFO and restarts fetch at a new pc.
module instr_fetch #(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_gnt,
   input  logic       mem_rvalid,
   input  logic [7:0] mem_rdata,
   output logic [7:0] instr,
   output logic       instr_valid,
   input  logic       instr_ready,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic [7:0] pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t          state_reg, state_next;
   logic [7:0]      pc_reg, pc_next;
   logic [7:0]      queue_mem [DEPTH];
   logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]   count_reg, count_next, count_after_pop, credits;
   logic [7:0]      instr_reg, instr_next;
   logic            instr_valid_reg, instr_valid_next;
   logic            push, pop;

   // A response only lands in the queue when it belongs to the live request;
   // a redirect in the same cycle discards both the response and any pop.
   assign push            = (state_reg == WAIT) && mem_rvalid && !redirect;
   assign pop             = instr_valid_reg && instr_ready && !redirect;
   assign count_after_pop = count_reg - CW'(pop);
   assign credits         = count_reg + CW'(state_reg == WAIT);

   // Fetch FSM: next state and next pc.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         IDLE: begin
            if (redirect)
               pc_next = redirect_pc;
            else if (credits < CW'(DEPTH))
               state_next = REQ;
         end
         REQ: begin
            if (redirect) begin
               pc_next    = redirect_pc;
               state_next = mem_gnt ? DROP : IDLE;
            end else if (mem_gnt) begin
               pc_next    = pc_reg + 8'd1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               pc_next    = redirect_pc;
               state_next = mem_rvalid ? IDLE : DROP;
            end else if (mem_rvalid) begin
               state_next = (count_next < CW'(DEPTH)) ? REQ : IDLE;
            end
         end
         DROP: begin
            // A response arriving with a redirect still retires the stale read,
            // otherwise DROP would wait for a response that never comes.
            if (redirect)
               pc_next = redirect_pc;
            if (mem_rvalid)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Queue bookkeeping and the registered head-of-queue value.
   always_comb begin
      count_next       = count_after_pop + CW'(push);
      rd_ptr_next      = rd_ptr_reg + AW'(pop);
      wr_ptr_next      = wr_ptr_reg + AW'(push);
      instr_next       = instr_reg;
      instr_valid_next = 1'b0;
      if (redirect) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
      end else if (count_after_pop != '0) begin
         instr_valid_next = 1'b1;
         instr_next       = queue_mem[rd_ptr_next];
      end else if (push) begin
         // Empty queue: the arriving byte bypasses storage to the head.
         instr_valid_next = 1'b1;
         instr_next       = mem_rdata;
      end
   end

   // Queue storage write; entries need no reset since count gates their use.
   always_ff @(posedge clk) begin
      if (push)
         queue_mem[wr_ptr_reg] <= mem_rdata;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_PC;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         count_reg       <= '0;
         instr_reg       <= 8'h00;
         instr_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
         count_reg       <= count_next;
         instr_reg       <= instr_next;
         instr_valid_reg <= instr_valid_next;
      end
   end

   assign mem_req     = (state_reg == REQ);
   assign mem_addr    = pc_reg;
   assign pc          = pc_reg;
   assign instr       = instr_reg;
   assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural memory and a scoreboard
// of expected instruction bytes.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_gnt = 1'b0;
   logic       mem_rvalid = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic       redirect = 1'b0;
   logic [7:0] redirect_pc = 8'h00;
   logic [7:0] pc;

   instr_fetch #(.DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   int         vecs = 0;
   int         errs = 0;
   bit         gnt_en = 1'b0;
   int         lat = 1;
   bit         pend = 1'b0;
   int         pend_cnt = 0;
   logic [7:0] pend_data = 8'h00;
   bit         pend_drop = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_pc = 8'h00;
   int         gcnt = 0;
   bit         ovr_en = 1'b0;
   logic [7:0] ovr_data = 8'h00;
   bit         saw_aa = 1'b0;
   bit         lat_v = 1'b0;
   logic [7:0] lat_b = 8'h00;

   function automatic logic [7:0] memf(input logic [7:0] a);
      return a ^ 8'h3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check the head, model the memory, then step past the edge.
   task automatic cyc(input bit rd, input logic [7:0] rpc);
      logic [7:0] b;
      redirect    = rd;
      redirect_pc = rpc;
      if (lat_v) begin
         chk("latency", 32'({instr_valid, instr}), 32'({1'b1, lat_b}));
         lat_v = 1'b0;
      end
      if (instr_valid && instr == 8'hAA)
         saw_aa = 1'b1;
      if (instr_valid && instr_ready && !rd) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'(instr), 32'hFFFF_FFFF);
         end else begin
            b = exp_q.pop_front();
            chk("sb_instr", 32'(instr), 32'(b));
         end
      end
      if (rd)
         exp_q.delete();
      mem_rvalid = 1'b0;
      mem_rdata  = 8'($urandom);
      if (pend) begin
         if (pend_cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_data;
            pend       = 1'b0;
            if (!pend_drop && !rd) begin
               if (exp_q.size() == 0) begin
                  lat_v = 1'b1;
                  lat_b = pend_data;
               end
               exp_q.push_back(pend_data);
            end
         end else begin
            pend_cnt--;
            if (rd)
               pend_drop = 1'b1;
         end
      end
      mem_gnt = 1'b0;
      if (mem_req && gnt_en && !pend) begin
         mem_gnt = 1'b1;
         gcnt++;
         chk("grant_addr", 32'(mem_addr), 32'(exp_pc));
         pend      = 1'b1;
         pend_cnt  = lat;
         pend_drop = rd;
         pend_data = ovr_en ? ovr_data : memf(mem_addr);
         ovr_en    = 1'b0;
      end
      if (rd)
         exp_pc = rpc;
      else if (mem_gnt)
         exp_pc = exp_pc + 8'd1;
      @(posedge clk);
      #1;
      redirect   = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   task automatic tick();
      cyc(1'b0, 8'h00);
   endtask

   initial begin
      // Reset values, with a spurious response that must be ignored.
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h77;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h00);
      chk("rst_pc", 32'(pc), 32'h00);
      chk("rst_instr", 32'(instr), 32'h00);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      mem_rvalid = 1'b0;

      // Release: first request follows one edge later.
      rst = 1'b1;
      chk("rel_mem_req", 32'(mem_req), 32'd0);
      tick();
      chk("first_req", 32'(mem_req), 32'd1);
      chk("first_addr", 32'(mem_addr), 32'h00);

      // Streaming: grant same cycle, data one cycle later, decoder always ready.
      gnt_en = 1'b1; lat = 1; instr_ready = 1'b1; gcnt = 0;
      repeat (20) tick();
      chk("rate_grants", 32'(gcnt), 32'd10);
      gnt_en = 1'b0;
      repeat (3) tick();
      chk("drain_stream", 32'(exp_q.size()), 32'd0);

      // Back-pressure: queue fills after exactly DEPTH grants.
      instr_ready = 1'b0; gnt_en = 1'b1; lat = 2; gcnt = 0;
      repeat (24) tick();
      chk("full_grants", 32'(gcnt), 32'd4);
      chk("full_req", 32'(mem_req), 32'd0);
      chk("full_valid", 32'(instr_valid), 32'd1);
      instr_ready = 1'b1; gcnt = 0;
      for (int i = 0; i < 4; i++) begin
         chk("pop_valid", 32'(instr_valid), 32'd1);
         tick();
      end
      repeat (4) tick();
      chk("resume_grants", 32'(gcnt >= 1), 32'd1);
      gnt_en = 1'b0;
      repeat (6) tick();
      chk("drain_full", 32'(exp_q.size()), 32'd0);

      // Redirect in REQ without grant, then pc wrap past 8'hFF.
      cyc(1'b1, 8'hFE);
      chk("redir_noreq", 32'(mem_req), 32'd0);
      chk("redir_pc", 32'(pc), 32'hFE);
      gnt_en = 1'b1; lat = 1;
      repeat (4) tick();
      chk("wrap_pc", 32'(pc), 32'h00);
      tick();
      chk("wrap_addr", 32'(mem_addr), 32'h00);
      gnt_en = 1'b0;
      repeat (3) tick();
      chk("drain_wrap", 32'(exp_q.size()), 32'd0);

      // Redirect to 8'h40 while waiting; the late 8'hAA response is discarded.
      ovr_en = 1'b1; ovr_data = 8'hAA; lat = 3; gnt_en = 1'b1; saw_aa = 1'b0;
      tick();
      gnt_en = 1'b0;
      cyc(1'b1, 8'h40);
      chk("wait_redir_pc", 32'(pc), 32'h40);
      chk("wait_redir_req", 32'(mem_req), 32'd0);
      tick();
      tick();
      tick();
      chk("wait_redir_addr", 32'(mem_addr), 32'h40);
      chk("wait_redir_reqon", 32'(mem_req), 32'd1);
      gnt_en = 1'b1; lat = 1;
      repeat (8) tick();
      gnt_en = 1'b0;
      repeat (3) tick();
      chk("no_aa", 32'(saw_aa), 32'd0);
      chk("drain_wait", 32'(exp_q.size()), 32'd0);

      // Redirect coincident with the grant of address 8'h05.
      cyc(1'b1, 8'h05);
      tick();
      chk("coinc_pre_addr", 32'(mem_addr), 32'h05);
      gnt_en = 1'b1; lat = 1;
      cyc(1'b1, 8'h20);
      gnt_en = 1'b0;
      chk("coinc_pc", 32'(pc), 32'h20);
      chk("coinc_req", 32'(mem_req), 32'd0);
      tick();
      chk("coinc_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("coinc_addr", 32'(mem_addr), 32'h20);
      chk("coinc_reqon", 32'(mem_req), 32'd1);

      // Reset pulse while a read is outstanding.
      instr_ready = 1'b0; gnt_en = 1'b1; lat = 1;
      repeat (4) tick();
      lat = 3;
      tick();
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", 32'(mem_req), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'h00);
      chk("mid_rst_pc", 32'(pc), 32'h00);
      chk("mid_rst_instr", 32'(instr), 32'h00);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      exp_q.delete();
      pend_drop = 1'b1;
      exp_pc    = 8'h00;
      lat_v     = 1'b0;
      gnt_en    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) tick();
      chk("stale_valid", 32'(instr_valid), 32'd0);
      chk("stale_addr", 32'(mem_addr), 32'h00);
      gnt_en = 1'b1; lat = 1; instr_ready = 1'b1;
      repeat (10) tick();
      gnt_en = 1'b0;
      repeat (4) tick();
      chk("drain_final", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
